// File: rtl/rbus_pkg.sv
// Shared types and constants for the packet-routed rbus crossbar.
package rbus_pkg;
  localparam int RBUS_DW   = 72;
  localparam int MAXPKT    = 16;
  localparam int LEN_W     = 4;
  localparam int DST_CHK_W = 4;
  localparam int DST_LSB_D = 64;
  localparam int LEN_LSB_D = 56;
  localparam int PRI_BIT_D = 60;

  typedef enum logic {IDLE, BODY} in_state_t;
  typedef enum logic {O_IDLE, O_BUSY} out_state_t;
endpackage

// File: rtl/rbus_xbar_in_fifo.sv
// Per-input packet framer and word FIFO: validates framing on entry and
// presents the decoded header of the word at the FIFO head.
module rbus_xbar_in_fifo
  import rbus_pkg::*;
#(
  parameter int M       = 4,
  parameter int DEPTH   = 64,
  parameter int DST_LSB = DST_LSB_D,
  parameter int LEN_LSB = LEN_LSB_D,
  parameter int PRI_BIT = PRI_BIT_D,
  parameter int DSTW    = (M > 1) ? $clog2(M) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_stb,
  input  logic               i_sof,
  input  logic [RBUS_DW-1:0] i_data,
  input  logic               i_pop,
  output logic [1:0]         o_rdy,
  output logic [1:0]         o_rdyE,
  output logic               o_empty,
  output logic               o_is_hdr,
  output logic [DSTW-1:0]    o_dst,
  output logic               o_pri,
  output logic [LEN_W-1:0]   o_len,
  output logic [RBUS_DW-1:0] o_head,
  output logic               o_err
);
  localparam int AW = $clog2(DEPTH);

  logic [RBUS_DW:0]     r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_cnt;
  in_state_t            r_state;
  logic [LEN_W-1:0]     r_left;
  logic [AW:0]          w_free;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_err;
  logic [DST_CHK_W-1:0] w_dst_chk;
  logic [LEN_W-1:0]     w_in_len;
  logic [RBUS_DW:0]     w_ent;

  assign w_free    = (AW+1)'(DEPTH) - r_cnt;
  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  // Range check spans the whole nibble so codes beyond clog2(M) bits are rejected too.
  assign w_dst_chk = i_data[DST_LSB +: DST_CHK_W];
  assign w_in_len  = i_data[LEN_LSB +: LEN_W];
  assign w_rd      = i_pop && (r_cnt != '0);

  always_comb begin
    w_wr  = 1'b0;
    w_err = 1'b0;
    if (i_stb) begin
      if (r_state == IDLE) begin
        if (!i_sof || int'(w_dst_chk) >= M || w_full) w_err = 1'b1;
        else                                          w_wr  = 1'b1;
      end else begin
        if (i_sof || w_full) w_err = 1'b1;
        else                 w_wr  = 1'b1;
      end
    end
  end

  // Payload words are counted even when dropped so framing stays aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_left  <= '0;
    end else if (i_stb) begin
      if (r_state == IDLE) begin
        if (w_wr && w_in_len != '0) begin
          r_state <= BODY;
          r_left  <= w_in_len;
        end
      end else if (!i_sof) begin
        r_left <= r_left - 1'b1;
        if (r_left == LEN_W'(1)) r_state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {i_sof, i_data};
  end

  assign w_ent    = r_mem[r_rptr];
  assign o_empty  = (r_cnt == '0);
  assign o_is_hdr = !o_empty && w_ent[RBUS_DW];
  assign o_dst    = w_ent[DST_LSB +: DSTW];
  assign o_pri    = w_ent[PRI_BIT];
  assign o_len    = w_ent[LEN_LSB +: LEN_W];
  assign o_head   = w_ent[RBUS_DW-1:0];
  assign o_rdy    = {2{w_free >= (AW+1)'(MAXPKT)}};
  assign o_rdyE   = {2{w_free >= (AW+1)'(2*MAXPKT)}};
  assign o_err    = w_err;
endmodule

// File: rtl/rbus_xbar_nxm.sv
// N-input x M-output packet crossbar: per-output arbiters (lane priority, then
// round-robin) hold a grant for a whole packet and forward one word per clock.
module rbus_xbar_nxm
  import rbus_pkg::*;
#(
  parameter int N       = 2,
  parameter int M       = 4,
  parameter int DEPTH   = 64,
  parameter int DST_LSB = DST_LSB_D,
  parameter int LEN_LSB = LEN_LSB_D,
  parameter int PRI_BIT = PRI_BIT_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_stb,
  input  logic [N-1:0]         i_sof,
  input  logic [N*RBUS_DW-1:0] i_data,
  output logic [2*N-1:0]       i_rdy,
  output logic [2*N-1:0]       i_rdyE,
  output logic [M-1:0]         o_stb,
  output logic [M-1:0]         o_sof,
  output logic [M*RBUS_DW-1:0] o_data,
  input  logic [2*M-1:0]       o_rdy,
  input  logic [2*M-1:0]       o_rdyE,
  output logic                 ff_err
);
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int DSTW = (M > 1) ? $clog2(M) : 1;

  logic [RBUS_DW-1:0] w_head [N];
  logic [DSTW-1:0]    w_dst  [N];
  logic [LEN_W-1:0]   w_len  [N];
  logic [N-1:0]       w_empty, w_is_hdr, w_pri, w_err, w_pop, w_busy_in;
  logic               w_gnt  [M];
  logic [IW-1:0]      w_win  [M];
  out_state_t         r_ost  [M];
  logic [IW-1:0]      r_sel  [M];
  logic [IW-1:0]      r_ptr  [M];
  logic [LEN_W-1:0]   r_left [M];
  logic               w_unused_rdyE;

  assign w_unused_rdyE = ^o_rdyE;

  for (genvar gi = 0; gi < N; gi++) begin : g_in
    rbus_xbar_in_fifo #(
      .M(M), .DEPTH(DEPTH), .DST_LSB(DST_LSB), .LEN_LSB(LEN_LSB),
      .PRI_BIT(PRI_BIT), .DSTW(DSTW)
    ) u_fifo (
      .clk(clk), .rst_n(rst_n),
      .i_stb(i_stb[gi]), .i_sof(i_sof[gi]),
      .i_data(i_data[gi*RBUS_DW +: RBUS_DW]), .i_pop(w_pop[gi]),
      .o_rdy(i_rdy[2*gi +: 2]), .o_rdyE(i_rdyE[2*gi +: 2]),
      .o_empty(w_empty[gi]), .o_is_hdr(w_is_hdr[gi]), .o_dst(w_dst[gi]),
      .o_pri(w_pri[gi]), .o_len(w_len[gi]), .o_head(w_head[gi]),
      .o_err(w_err[gi])
    );
  end

  always_comb begin
    w_busy_in = '0;
    for (int m = 0; m < M; m++)
      if (r_ost[m] == O_BUSY) w_busy_in[r_sel[m]] = 1'b1;
  end

  // Lane 1 is scanned first; within a lane the scan starts just after the last winner.
  always_comb begin
    int j;
    j     = 0;
    w_pop = '0;
    for (int m = 0; m < M; m++) begin
      w_gnt[m] = 1'b0;
      w_win[m] = '0;
      for (int l = 1; l >= 0; l--) begin
        for (int k = 1; k <= N; k++) begin
          j = (int'(r_ptr[m]) + k) % N;
          if (!w_gnt[m] && r_ost[m] == O_IDLE && w_is_hdr[j] && !w_busy_in[j] &&
              int'(w_dst[j]) == m && int'(w_pri[j]) == l && o_rdy[2*m+l]) begin
            w_gnt[m] = 1'b1;
            w_win[m] = IW'(j);
          end
        end
      end
      if (w_gnt[m])
        w_pop[w_win[m]] = 1'b1;
      else if (r_ost[m] == O_BUSY && !w_empty[r_sel[m]])
        w_pop[r_sel[m]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stb  <= '0;
      o_sof  <= '0;
      o_data <= '0;
      ff_err <= 1'b0;
      for (int m = 0; m < M; m++) begin
        r_ost[m]  <= O_IDLE;
        r_sel[m]  <= '0;
        r_ptr[m]  <= '0;
        r_left[m] <= '0;
      end
    end else begin
      ff_err <= ff_err | (|w_err);
      for (int m = 0; m < M; m++) begin
        o_stb[m] <= 1'b0;
        o_sof[m] <= 1'b0;
        if (w_gnt[m]) begin
          o_stb[m] <= 1'b1;
          o_sof[m] <= 1'b1;
          o_data[m*RBUS_DW +: RBUS_DW] <= w_head[w_win[m]];
          r_ptr[m] <= w_win[m];
          if (w_len[w_win[m]] != '0) begin
            r_ost[m]  <= O_BUSY;
            r_sel[m]  <= w_win[m];
            r_left[m] <= w_len[w_win[m]];
          end
        end else if (r_ost[m] == O_BUSY && !w_empty[r_sel[m]]) begin
          o_stb[m] <= 1'b1;
          o_data[m*RBUS_DW +: RBUS_DW] <= w_head[r_sel[m]];
          r_left[m] <= r_left[m] - 1'b1;
          if (r_left[m] == LEN_W'(1)) r_ost[m] <= O_IDLE;
        end
      end
    end
  end
endmodule
